vga_timing_gen: RTL

- Generates 640x480 @ 60 Hz VGA raster timing from the 50 MHz board clock.
- Drives the pixel coordinates (x, y) and the visible-area flag pixel_on that feed the colour stage directly downstream.
- Drives hsync/vsync to the DAC/connector, plus pixel-tick and frame-start strobes for other consumers.

---
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_timing_gen.sv | 100 ++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the colour stage,
// the DAC sync pins and the strobe consumers.
interface vga_timing_gen_if;
   logic [9:0] x;
   logic [9:0] y;
   logic       pixel_on;
   logic       hsync_Out;
   logic       vsync_Out;
   logic       pix_tick_Out;
   logic       frame_start_Out;

   modport master (
      output x,
      output y,
      output pixel_on,
      output hsync_Out,
      output vsync_Out,
      output pix_tick_Out,
      output frame_start_Out
   );

   modport slave (
      input x,
      input y,
      input pixel_on,
      input hsync_Out,
      input vsync_Out,
      input pix_tick_Out,
      input frame_start_Out
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, horizontal/vertical counters and
// registered, mutually aligned pixel_on / sync / strobe outputs.
module vga_timing_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic             clk,
   input  logic             reset,
   vga_timing_gen_if.master vga_o
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int CW      = 10;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
   localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_VISIBLE + H_FRONT);
   localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_VISIBLE + V_FRONT);
   localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;
   logic          tick_q, tick_d;
   logic          pix_on_q, pix_on_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          frame_q, frame_d;
   logic          h_wrap;
   logic          v_wrap;

   // The registered tick marks the edge on which the counters advance, so it
   // stays low in reset even when CLK_DIV is 1.
   always_comb begin
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      h_wrap = tick_q && (h_q == H_LAST);
      v_wrap = h_wrap && (v_q == V_LAST);

      h_d = h_q;
      if (tick_q) begin
         h_d = h_wrap ? '0 : h_q + 1'b1;
      end

      v_d = v_q;
      if (h_wrap) begin
         v_d = v_wrap ? '0 : v_q + 1'b1;
      end

      // Decode from the next counter values so every output lines up with x/y.
      tick_d   = (div_d == DIV_LAST);
      pix_on_d = (h_d < H_VIS) && (v_d < V_VIS);
      hsync_d  = !((h_d >= HS_BEG) && (h_d < HS_END));
      vsync_d  = !((v_d >= VS_BEG) && (v_d < VS_END));
      frame_d  = v_wrap;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q    <= '0;
         h_q      <= '0;
         v_q      <= '0;
         tick_q   <= 1'b0;
         pix_on_q <= 1'b0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         frame_q  <= 1'b0;
      end else begin
         div_q    <= div_d;
         h_q      <= h_d;
         v_q      <= v_d;
         tick_q   <= tick_d;
         pix_on_q <= pix_on_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         frame_q  <= frame_d;
      end
   end

   assign vga_o.x               = h_q;
   assign vga_o.y               = v_q;
   assign vga_o.pixel_on        = pix_on_q;
   assign vga_o.hsync_Out       = hsync_q;
   assign vga_o.vsync_Out       = vsync_q;
   assign vga_o.pix_tick_Out    = tick_q;
   assign vga_o.frame_start_Out = frame_q;

endmodule
